// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES stream adapter: FSM encoding, block width
// and the beat-count helper used to size the word counters.
package aes_stream_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_DATA  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    function automatic int beats(input int width, input int bus);
        return width / bus;
    endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// MSB-first word shift register: parallel load, shift-in at the bottom, and
// the top word exposed for shift-out. Shared by key, block and result paths.
module aes_word_shifter #(
    parameter int WIDTH = 128,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic [BUS_W-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shifted,
    output logic [BUS_W-1:0] top
);

    // shifted is the value after this beat, so callers can capture a
    // completed word in the same edge that accepts its last beat
    generate
        if (WIDTH == BUS_W) begin : g_single
            assign shifted = din;
        end else begin : g_multi
            assign shifted = {q[WIDTH-BUS_W-1:0], din};
        end
    endgenerate

    assign top = q[WIDTH-1 -: BUS_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       q <= '0;
        else if (load)  q <= load_val;
        else if (shift) q <= shifted;
    end

endmodule

// File: rtl/aes_stream_adapter.sv
// Streams key and plaintext words into a block-parallel AES core and streams
// the 128-bit result back out, with valid/ready on every channel.
module aes_stream_adapter
    import aes_stream_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int KEY_W = 128,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUS_W-1:0]   key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [BUS_W-1:0]   data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic [BUS_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_block,
    output logic               core_start,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result,
    output logic               key_loaded,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_count
);

    localparam int KEY_BEATS = beats(KEY_W, BUS_W);
    localparam int BLK_BEATS = beats(BLOCK_W, BUS_W);
    localparam int MAX_BEATS = (KEY_BEATS > BLK_BEATS) ? KEY_BEATS : BLK_BEATS;
    localparam int CW        = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BEATS - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BEATS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          key_done, blk_done, out_done, res_load;
    logic          key_fire, data_fire, out_fire;

    logic [KEY_W-1:0]   key_q, key_shifted;
    logic [BUS_W-1:0]   key_top;
    logic [BLOCK_W-1:0] data_q, data_shifted;
    logic [BUS_W-1:0]   data_top;
    logic [BLOCK_W-1:0] out_q, out_shifted;

    assign key_fire  = key_valid && key_ready;
    assign data_fire = data_valid && data_ready;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        key_ready  = 1'b0;
        data_ready = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        key_done   = 1'b0;
        blk_done   = 1'b0;
        out_done   = 1'b0;
        res_load   = 1'b0;
        case (state)
            S_IDLE: begin
                // key wins over data so a reload is never starved by traffic
                key_ready  = 1'b1;
                data_ready = key_loaded && !key_valid;
                if (key_valid) begin
                    if (KEY_LAST == '0) begin
                        key_done = 1'b1;
                    end else begin
                        state_nxt = S_KEY;
                        cnt_nxt   = CW'(1);
                    end
                end else if (data_valid && key_loaded) begin
                    if (BLK_LAST == '0) begin
                        blk_done  = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_DATA;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            S_KEY: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    if (cnt == KEY_LAST) begin
                        key_done  = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    if (cnt == BLK_LAST) begin
                        blk_done  = 1'b1;
                        state_nxt = S_START;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_START: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    res_load  = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt == BLK_LAST) begin
                        out_done  = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            core_key   <= '0;
            key_loaded <= 1'b0;
            core_block <= '0;
            blk_count  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // core_key is the shadow: only a complete staged key reaches it
            if (key_done) begin
                core_key   <= key_shifted;
                key_loaded <= 1'b1;
            end
            if (blk_done) core_block <= data_shifted;
            if (out_done) blk_count <= blk_count + 1'b1;
        end
    end

    aes_word_shifter #(.WIDTH(KEY_W), .BUS_W(BUS_W)) u_key_stage (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
        .shift(key_fire), .din(key_in),
        .q(key_q), .shifted(key_shifted), .top(key_top)
    );

    aes_word_shifter #(.WIDTH(BLOCK_W), .BUS_W(BUS_W)) u_blk_stage (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
        .shift(data_fire), .din(data_in),
        .q(data_q), .shifted(data_shifted), .top(data_top)
    );

    aes_word_shifter #(.WIDTH(BLOCK_W), .BUS_W(BUS_W)) u_out_stage (
        .clk(clk), .rst(rst), .load(res_load), .load_val(core_result),
        .shift(out_fire), .din('0),
        .q(out_q), .shifted(out_shifted), .top(out_data)
    );

    logic unused_ok;
    assign unused_ok = ^{key_q, key_top, data_q, data_top, out_q, out_shifted};

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Bench for aes_stream_adapter: two instances (8-bit/128-bit key and
// 64-bit/256-bit key), each driving a delayed XOR stub in place of the core.
module tb_aes_stream_adapter;

    localparam logic [127:0] KV  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] DV  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] RV  = 128'h001F0E543C4E08596E221B0B4774311A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: BUS_W=8, KEY_W=128
    logic [7:0]   key_in, data_in, out_data;
    logic         key_valid, key_ready, data_valid, data_ready;
    logic         out_valid, out_ready, core_start, core_done, key_loaded, busy;
    logic [127:0] core_key, core_block, core_result;
    logic [15:0]  blk_count;

    aes_stream_adapter #(.BUS_W(8), .KEY_W(128), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_key(core_key), .core_block(core_block), .core_start(core_start),
        .core_done(core_done), .core_result(core_result),
        .key_loaded(key_loaded), .busy(busy), .blk_count(blk_count)
    );

    // instance B: BUS_W=64, KEY_W=256
    logic [63:0]  key_in_b, data_in_b, out_data_b;
    logic         key_valid_b, key_ready_b, data_valid_b, data_ready_b;
    logic         out_valid_b, out_ready_b, core_start_b, core_done_b, key_loaded_b, busy_b;
    logic [255:0] core_key_b;
    logic [127:0] core_block_b, core_result_b;
    logic [7:0]   blk_count_b;

    aes_stream_adapter #(.BUS_W(64), .KEY_W(256), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .key_in(key_in_b), .key_valid(key_valid_b), .key_ready(key_ready_b),
        .data_in(data_in_b), .data_valid(data_valid_b), .data_ready(data_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .core_key(core_key_b), .core_block(core_block_b), .core_start(core_start_b),
        .core_done(core_done_b), .core_result(core_result_b),
        .key_loaded(key_loaded_b), .busy(busy_b), .blk_count(blk_count_b)
    );

    // stub cores: result = block ^ key[127:0], done 5 cycles after start;
    // they ignore rst so a reset mid-wait leaves a late done in flight
    int unsigned starts = 0, dones = 0, starts_b = 0;
    logic [3:0]   dly = '0, dly_b = '0;
    logic [127:0] hold_res, hold_res_b;
    initial begin
        core_done = 1'b0; core_result = '0; core_done_b = 1'b0; core_result_b = '0;
    end
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            dly <= 4'd5; hold_res <= core_block ^ core_key; starts <= starts + 1;
        end else if (dly != 0) begin
            dly <= dly - 1'b1;
            if (dly == 1) begin core_done <= 1'b1; core_result <= hold_res; end
        end
        if (core_done) dones <= dones + 1;
        core_done_b <= 1'b0;
        if (core_start_b) begin
            dly_b <= 4'd5; hold_res_b <= core_block_b ^ core_key_b[127:0]; starts_b <= starts_b + 1;
        end else if (dly_b != 0) begin
            dly_b <= dly_b - 1'b1;
            if (dly_b == 1) begin core_done_b <= 1'b1; core_result_b <= hold_res_b; end
        end
    end

    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drives words first..last-1 of v (MSB-first) on the key or data channel
    task automatic send(input bit is_key, input logic [127:0] v, input int first,
                        input int last, input bit gaps);
        logic [7:0] w;
        int guard;
        for (int i = first; i < last; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            w = v[127-8*i -: 8];
            if (is_key) begin key_in = w; key_valid = 1'b1; end
            else begin data_in = w; data_valid = 1'b1; end
            #1;
            guard = 0;
            while (!(is_key ? key_ready : data_ready) && guard < 200) begin
                @(negedge clk); #1; guard++;
            end
            if (guard >= 200) chk(is_key ? "key_ready_timeout" : "data_ready_timeout", 0, 1);
            @(negedge clk);
            key_valid = 1'b0; data_valid = 1'b0;
        end
    endtask

    // collects one 128-bit result with random out_ready, plus one 4-cycle stall
    task automatic get_out(output logic [127:0] r, input bit stalls);
        int beats_got, guard;
        bit stalled;
        logic [7:0] hold;
        r = '0; beats_got = 0; guard = 0; stalled = 0;
        while (beats_got < 16 && guard < 2000) begin
            @(negedge clk); guard++;
            if (stalls && !stalled && beats_got == 5 && out_valid) begin
                stalled = 1; out_ready = 1'b0; hold = out_data;
                repeat (4) begin
                    @(negedge clk); #1;
                    chk("stall_hold", out_data, hold);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                r = {r[119:0], out_data}; beats_got++;
            end
        end
        if (guard >= 2000) chk("out_timeout", beats_got, 16);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("out_drained", {busy, out_valid}, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_key_loaded"}, key_loaded, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_blk_count"}, blk_count, 0);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_core_block"}, core_block, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_readies"}, {key_ready, data_ready}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] mkey, d, r, k2, k3, rb, db;
    logic [255:0] kb;
    int unsigned mcount, s0, d0;
    int nb, guard;

    initial begin
        key_in = '0; key_valid = 0; data_in = '0; data_valid = 0; out_ready = 0;
        key_in_b = '0; key_valid_b = 0; data_in_b = '0; data_valid_b = 0; out_ready_b = 0;
        repeat (3) @(negedge clk);
        #1 reset_checks("por");
        @(negedge clk); rst = 1'b1;

        // data with no key loaded must wait
        @(negedge clk); data_in = 8'hAA; data_valid = 1'b1;
        repeat (4) begin @(negedge clk); #1; chk("data_before_key", {busy, data_ready}, 0); end
        data_valid = 1'b0;

        // known vector
        send(1, KV, 0, 16, 0);
        #1 chk("vec_key_loaded", key_loaded, 1);
        chk("vec_core_key", core_key, KV);
        mkey = KV; mcount = 0;
        send(0, DV, 0, 16, 0);
        #1 chk("start_latency", core_start, 1);
        chk("vec_core_block", core_block, DV);
        @(negedge clk); #1 chk("start_one_cycle", core_start, 0);
        get_out(r, 0);
        mcount++;
        chk("vec_result_const", r, RV);
        chk("vec_result_model", r, DV ^ mkey);
        chk("vec_blk_count", blk_count, mcount);

        // key wins when key and data are valid together; shadow key holds during partial load
        k2 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        key_in = k2[127:120]; key_valid = 1'b1; data_in = 8'h55; data_valid = 1'b1;
        #1 chk("prio_data_ready", {key_ready, data_ready}, 2'b10);
        @(negedge clk);
        key_valid = 1'b0; data_valid = 1'b0;
        #1 chk("prio_in_key", {busy, data_ready}, 2'b10);
        send(1, k2, 1, 7, 1);
        chk("shadow_stable", core_key, KV);
        chk("shadow_loaded", key_loaded, 1);
        send(1, k2, 7, 16, 1);
        #1 chk("key2_loaded", core_key, k2);
        mkey = k2;

        // key reuse over three blocks with gaps and stalls
        s0 = starts;
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(0, d, 0, 16, 1);
            get_out(r, 1);
            mcount++;
            chk("reuse_result", r, d ^ mkey);
            chk("reuse_blk_count", blk_count, mcount);
        end
        chk("reuse_starts", starts - s0, 3);

        // reset after 7 key bytes, then after 9 data bytes
        k3 = {$urandom, $urandom, $urandom, $urandom};
        d  = {$urandom, $urandom, $urandom, $urandom};
        send(1, k3, 0, 7, 0);
        #3 rst = 1'b0;
        #1 reset_checks("rst_key");
        @(negedge clk); rst = 1'b1;
        send(1, k3, 0, 16, 0);
        send(0, d, 0, 9, 0);
        #3 rst = 1'b0;
        #1 reset_checks("rst_data");
        @(negedge clk); rst = 1'b1;
        mkey = '0; mcount = 0;

        // reset while the core is working: its late done must be ignored
        send(1, k3, 0, 16, 0);
        send(0, d, 0, 16, 0);
        d0 = dones;
        @(negedge clk);
        #3 rst = 1'b0;
        #1 reset_checks("rst_wait");
        @(negedge clk); rst = 1'b1;
        repeat (8) begin
            @(negedge clk); #1;
            chk("late_done_ignored", {busy, out_valid}, 0);
        end
        chk("late_done_seen", dones - d0, 1);

        // full operation after the resets
        send(1, k3, 0, 16, 0);
        mkey = k3;
        send(0, d, 0, 16, 1);
        get_out(r, 1);
        mcount++;
        chk("post_rst_result", r, d ^ mkey);
        chk("post_rst_blk_count", blk_count, mcount);

        // wide instance: 4 key beats, 2 data beats
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        db = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); key_in_b = kb[255-64*i -: 64]; key_valid_b = 1'b1;
            #1 chk("b_key_ready", key_ready_b, 1);
        end
        @(negedge clk); key_valid_b = 1'b0;
        #1 chk("b_key_loaded", key_loaded_b, 1);
        chk("b_core_key", core_key_b, kb);
        s0 = starts_b;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); data_in_b = db[127-64*i -: 64]; data_valid_b = 1'b1;
            #1 chk("b_data_ready", data_ready_b, 1);
        end
        @(negedge clk); data_valid_b = 1'b0;
        #1 chk("b_core_block", core_block_b, db);
        out_ready_b = 1'b1; rb = '0; nb = 0; guard = 0;
        while (nb < 2 && guard < 100) begin
            @(negedge clk); #1; guard++;
            if (out_valid_b) begin rb = {rb[63:0], out_data_b}; nb++; end
        end
        if (guard >= 100) chk("b_out_timeout", nb, 2);
        @(negedge clk); out_ready_b = 1'b0;
        #1 chk("b_result", rb, db ^ kb[127:0]);
        chk("b_start_once", starts_b - s0, 1);
        chk("b_blk_count", blk_count_b, 1);
        chk("b_idle", busy_b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
